uart_tx_serializer: RTL

Serial UART transmitter that consumes the byte/strobe handshake produced by the TX buffer FSM (`d_in`, `tx_start`) and drives the `tx` line with an 8N1-style frame. It has an optional parity bit and an internal baud-tick generator. It reports availability back to the buffer through the level signal `tx_done`. The buffer raises `tx_start` only while `tx_done` is 1 and drops it once `tx_done` falls.

---
 rtl/uart_tx_serializer.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_serializer.sv
// UART transmitter: serializes one DBIT-wide byte per tx_start acceptance into an
// 8N1-style frame with optional parity, driven by an internal oversampling tick.
module uart_tx_serializer #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int DVSR    = 326,
    parameter int PARITY  = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_start,
    input  logic [7:0] d_in,
    output logic       tx_done,
    output logic       tx
);

    localparam int CW = $clog2(DVSR + 1);
    localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
    localparam int NW = $clog2(DBIT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   tick_cnt_q, tick_cnt_d;
    logic [SW-1:0]   s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] shreg_q, shreg_d;
    logic            par_q, par_d;
    logic            tx_q, tx_d;
    logic            done_q, done_d;
    logic            tick;

    assign tick = (tick_cnt_q == CW'(DVSR - 1));

    // tx_d/done_d are computed from the next state so the outputs change on the
    // same edge as the state itself.
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick ? '0 : tick_cnt_q + CW'(1);
        s_d        = s_q;
        n_d        = n_q;
        shreg_d    = shreg_q;
        par_d      = par_q;
        tx_d       = tx_q;
        done_d     = done_q;

        case (state_q)
            S_IDLE: begin
                tick_cnt_d = '0;
                tx_d       = 1'b1;
                done_d     = 1'b1;
                if (tx_start) begin
                    shreg_d = d_in[DBIT-1:0];
                    par_d   = (^d_in[DBIT-1:0]) ^ (PARITY == 2);
                    s_d     = '0;
                    n_d     = '0;
                    state_d = S_START;
                    tx_d    = 1'b0;
                    done_d  = 1'b0;
                end
            end
            S_START: begin
                if (tick) begin
                    if (s_q == SW'(15)) begin
                        s_d     = '0;
                        state_d = S_DATA;
                        tx_d    = shreg_q[0];
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (s_q == SW'(15)) begin
                        s_d     = '0;
                        shreg_d = shreg_q >> 1;
                        if (n_q == NW'(DBIT - 1)) begin
                            if (PARITY != 0) begin
                                state_d = S_PAR;
                                tx_d    = par_q;
                            end else begin
                                state_d = S_STOP;
                                tx_d    = 1'b1;
                            end
                        end else begin
                            n_d  = n_q + NW'(1);
                            tx_d = shreg_q[1];
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            S_PAR: begin
                if (tick) begin
                    if (s_q == SW'(15)) begin
                        s_d     = '0;
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (s_q == SW'(SB_TICK - 1)) begin
                        s_d     = '0;
                        state_d = S_IDLE;
                        tx_d    = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
                done_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            tick_cnt_q <= '0;
            s_q        <= '0;
            n_q        <= '0;
            shreg_q    <= '0;
            par_q      <= 1'b0;
            tx_q       <= 1'b1;
            done_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            s_q        <= s_d;
            n_q        <= n_d;
            shreg_q    <= shreg_d;
            par_q      <= par_d;
            tx_q       <= tx_d;
            done_q     <= done_d;
        end
    end

    assign tx_done = done_q;
    assign tx      = tx_q;

endmodule
